ssg_bus_sequencer: RTL and testbench
====================================

SSG_BUS_SEQUENCER -- requirements
Module: ssg_bus_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYC, default 3: minimum cycles each bus phase (BYTE1, BYTE2) is driven; legal range 2..15.
REQ-002 SHALL have parameter GAP_CYC, default 2: cycles of bus-idle (BC=00) between commands and after errors; legal range 1..15.
REQ-003 SHALL have port CLK, input, 1: rising-edge clock.
REQ-004 SHALL have port RST, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1: sequencer enable; 0 aborts any in-flight command.
REQ-006 SHALL have port cmd_valid, input, 1: command offered.
REQ-007 SHALL have port cmd_data, input, 16: {byte1, byte2}; byte1[7:6] 1x=wavetable, 01=tone, 00=status.
REQ-008 SHALL have port cmd_ready, output, 1: FIFO can accept a command.
REQ-009 SHALL have port BUSY, input, 1: sound-chip busy.
REQ-010 SHALL have port BR, input, 1: sound-chip bus-error indication.
REQ-011 SHALL have port BusControl, output, 2: 00 idle, 01 byte1, 10 byte2; 11 never driven.
REQ-012 SHALL have port Data, output, 8: bus data.
REQ-013 SHALL have port done_pulse, output, 1: one-cycle pulse when a command completes.
REQ-014 SHALL have port err_pulse, output, 1: one-cycle pulse when a command is dropped on error.
REQ-015 SHALL have port err_count, output, 8: saturating error count.
REQ-016 SHALL have port fifo_level, output, 3: FIFO occupancy, 0..4.
REQ-017 SHALL have port idle, output, 1: high only in IDLE with fifo_level=0.

Function
REQ-018 SHALL buffer commands in a 4-deep FIFO; push when cmd_valid && cmd_ready; cmd_ready = (fifo_level<4), independent of cmd_valid.
REQ-019 SHALL, with push and pop in the same cycle, leave fifo_level unchanged; pointers wrap modulo 4.
REQ-020 SHALL implement states IDLE, B1, B2, GAP, ERR.
REQ-021 IDLE: BC=00, Data=00; when enable=1 and fifo_level>0, pop head into a current-command register and go to B1 next cycle.
REQ-022 B1: BC=01, Data=byte1; a phase counter clears on entry; exit when counter>=HOLD_CYC-1 and BUSY=0; go to B2 if byte1[7:6]!=00, else GAP.
REQ-023 B2: BC=10, Data=byte2; same exit rule as B1; go to GAP.
REQ-024 GAP: BC=00, Data=00 for exactly GAP_CYC cycles; on the last GAP cycle assert done_pulse, then go to IDLE.
REQ-025 SHALL go to ERR on the next edge when BR=1 is sampled in B1, B2 or GAP, or when the phase counter reaches 255 in B1/B2 (BUSY stuck); BR has priority over the normal phase exit.
REQ-026 ERR: BC=00, Data=00 for GAP_CYC cycles; the command is dropped (no retry) and done_pulse is not asserted; on the last cycle assert err_pulse, increment err_count saturating at 255, then go to IDLE.
REQ-027 With enable=0 in any state: go to IDLE next edge, drop the current command, assert no pulses, and issue no pops; pushes continue.
REQ-028 Minimum command length is HOLD_CYC+GAP_CYC cycles for status and 2*HOLD_CYC+GAP_CYC cycles for two-byte commands; back-to-back commands add 1 IDLE cycle.
REQ-029 BusControl and Data SHALL be registered outputs, glitch-free and stable for a whole phase.

Reset
REQ-030 RST low SHALL immediately force: state IDLE, FIFO empty, BusControl=00, Data=00, done_pulse=0, err_pulse=0, err_count=0, fifo_level=0, cmd_ready=1, idle=1.
REQ-031 Reset mid-command SHALL drop the command and all queued commands without pulses.

Verification
REQ-032 Tone cmd 0x5ABC, BUSY=0, defaults -> BC=01/Data=5A for 3 cycles, BC=10/Data=BC for 3 cycles, BC=00 for 2 cycles, done_pulse on the 8th cycle.
REQ-033 Status cmd 0x0D00 -> BC=01/Data=0D for 3 cycles, no BC=10 phase, done after 5 cycles.
REQ-034 Wavetable cmd 0xA512 with BUSY held high 4 extra cycles in B1 -> B1 lasts 7 cycles, then normal completion.
REQ-035 BR=1 during B2 -> BC=00 for 2 cycles, err_pulse, err_count 0->1, no done_pulse, next queued command starts.
REQ-036 Push 5 commands back-to-back while enable=0 -> 4 accepted, cmd_ready=0, fifo_level=4; raise enable -> 4 done_pulses in FIFO order.
REQ-037 BUSY stuck high in B1 -> ERR entered after 255 cycles; force 256 errors -> err_count=255.

Source files
------------

// File: rtl/ssg_bus_sequencer_if.sv
// Command/bus bundle for the sound-chip sequencer: host command handshake,
// status outputs and the two-phase chip bus with its BUSY/BR feedback.
interface ssg_bus_sequencer_if;
  logic        enable;
  logic        cmd_valid;
  logic [15:0] cmd_data;
  logic        cmd_ready;
  logic        BUSY;
  logic        BR;
  logic [1:0]  BusControl;
  logic [7:0]  Data;
  logic        done_pulse;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic [2:0]  fifo_level;
  logic        idle;

  modport master (
    output enable, cmd_valid, cmd_data, BUSY, BR,
    input  cmd_ready, BusControl, Data, done_pulse, err_pulse, err_count, fifo_level, idle
  );

  modport slave (
    input  enable, cmd_valid, cmd_data, BUSY, BR,
    output cmd_ready, BusControl, Data, done_pulse, err_pulse, err_count, fifo_level, idle
  );
endinterface

// File: rtl/ssg_bus_sequencer.sv
// Sound-chip bus sequencer: queues 16-bit commands in a 4-deep FIFO and plays
// each out as timed byte1/byte2 bus phases followed by an idle gap.
module ssg_bus_sequencer #(
  parameter int HOLD_CYC = 3,
  parameter int GAP_CYC  = 2
) (
  input logic CLK,
  input logic RST,
  ssg_bus_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, B1, B2, GAP, ERR} stateT;

  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);
  localparam logic [7:0] STUCK_LAST = 8'd254;

  stateT       state;
  logic [15:0] fifoMem [4];
  logic [1:0]  wrPtr;
  logic [1:0]  rdPtr;
  logic [2:0]  level;
  logic [15:0] curCmd;
  logic [15:0] headCmd;
  logic [7:0]  phaseCnt;
  logic [7:0]  errCount;
  logic [7:0]  dataOut;
  logic [1:0]  busCtl;
  logic        donePulse;
  logic        errPulse;
  logic        push;
  logic        pop;
  logic        phaseDone;
  logic        inBytePhase;
  logic        gotoErr;

  assign push        = bus.cmd_valid && (level < 3'd4);
  assign pop         = bus.enable && (state == IDLE) && (level != 3'd0);
  assign headCmd     = fifoMem[rdPtr];
  assign phaseDone   = (phaseCnt >= HOLD_LAST) && !bus.BUSY;
  assign inBytePhase = (state == B1) || (state == B2);
  // A stuck BUSY only counts as an error if the phase could not have ended normally.
  assign gotoErr     = (inBytePhase || (state == GAP)) &&
                       (bus.BR || (inBytePhase && !phaseDone && phaseCnt == STUCK_LAST));

  always_ff @(posedge CLK) begin
    if (push) fifoMem[wrPtr] <= bus.cmd_data;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wrPtr <= 2'd0;
      rdPtr <= 2'd0;
      level <= 3'd0;
    end else begin
      if (push) wrPtr <= wrPtr + 2'd1;
      if (pop)  rdPtr <= rdPtr + 2'd1;
      if (push && !pop)      level <= level + 3'd1;
      else if (pop && !push) level <= level - 3'd1;
    end
  end

  // Bus outputs and pulses are assigned alongside the state so they change only on phase boundaries.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      curCmd    <= 16'd0;
      phaseCnt  <= 8'd0;
      busCtl    <= 2'b00;
      dataOut   <= 8'd0;
      donePulse <= 1'b0;
      errPulse  <= 1'b0;
      errCount  <= 8'd0;
    end else begin
      donePulse <= 1'b0;
      errPulse  <= 1'b0;
      if (!bus.enable) begin
        state    <= IDLE;
        busCtl   <= 2'b00;
        dataOut  <= 8'd0;
        phaseCnt <= 8'd0;
      end else if (gotoErr) begin
        state    <= ERR;
        busCtl   <= 2'b00;
        dataOut  <= 8'd0;
        phaseCnt <= 8'd0;
        if (GAP_LAST == 8'd0) begin
          errPulse <= 1'b1;
          if (errCount != 8'hFF) errCount <= errCount + 8'd1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (pop) begin
              curCmd   <= headCmd;
              state    <= B1;
              busCtl   <= 2'b01;
              dataOut  <= headCmd[15:8];
              phaseCnt <= 8'd0;
            end
          end
          B1, B2: begin
            if (phaseDone) begin
              phaseCnt <= 8'd0;
              if (state == B1 && curCmd[15:14] != 2'b00) begin
                state   <= B2;
                busCtl  <= 2'b10;
                dataOut <= curCmd[7:0];
              end else begin
                state     <= GAP;
                busCtl    <= 2'b00;
                dataOut   <= 8'd0;
                donePulse <= (GAP_LAST == 8'd0);
              end
            end else begin
              phaseCnt <= phaseCnt + 8'd1;
            end
          end
          GAP: begin
            if (phaseCnt == GAP_LAST) begin
              state <= IDLE;
            end else begin
              phaseCnt  <= phaseCnt + 8'd1;
              donePulse <= (phaseCnt + 8'd1 == GAP_LAST);
            end
          end
          ERR: begin
            if (phaseCnt == GAP_LAST) begin
              state <= IDLE;
            end else begin
              phaseCnt <= phaseCnt + 8'd1;
              if (phaseCnt + 8'd1 == GAP_LAST) begin
                errPulse <= 1'b1;
                if (errCount != 8'hFF) errCount <= errCount + 8'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.cmd_ready  = (level < 3'd4);
  assign bus.fifo_level = level;
  assign bus.idle       = (state == IDLE) && (level == 3'd0);
  assign bus.BusControl = busCtl;
  assign bus.Data       = dataOut;
  assign bus.done_pulse = donePulse;
  assign bus.err_pulse  = errPulse;
  assign bus.err_count  = errCount;

endmodule

// File: tb/tb_ssg_bus_sequencer.sv
// Scoreboard bench for ssg_bus_sequencer: a chip responder shapes BUSY/BR per
// command, and a monitor matches every completion against predicted phase timing.
module tb_ssg_bus_sequencer;
  localparam int HOLD = 3;
  localparam int GAP  = 2;

  logic CLK;
  logic RST;
  ssg_bus_sequencer_if bus();

  ssg_bus_sequencer #(.HOLD_CYC(HOLD), .GAP_CYC(GAP)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    bit         isErr;
    bit         abort;
    logic [7:0] b1;
    logic [7:0] b2;
    int         b1Len;
    int         b2Len;
    int         tail;
  } expT;

  typedef struct {
    int extra;
    int br;
  } planT;

  expT  expQ[$];
  planT planQ[$];
  int   numVectors = 0;
  int   numMiscompares = 0;
  int   doneSeen = 0;
  int   errSeen = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input int act, input int exp);
    numVectors++;
    if (act != exp) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name, input string detail);
    numVectors++;
    numMiscompares++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  // Outcome of one command from its type, BUSY stretch in byte1 and BR phase (0 none, 1 B1, 2 B2, 3 GAP).
  function automatic expT predict(input logic [15:0] cmd, input int extra, input int br, input bit abort);
    expT e;
    bit twoByte;
    twoByte = (cmd[15:14] != 2'b00);
    e.isErr = 1'b0;
    e.abort = abort;
    e.b1    = cmd[15:8];
    e.b2    = cmd[7:0];
    e.b1Len = HOLD + extra;
    e.b2Len = 0;
    e.tail  = GAP;
    if (br == 1) begin
      e.isErr = 1'b1;
      e.b1Len = 1;
    end else if (HOLD + extra > 255) begin
      e.isErr = 1'b1;
      e.b1Len = 255;
    end else begin
      if (twoByte) e.b2Len = (br == 2) ? 1 : HOLD;
      if (twoByte && br == 2) begin
        e.isErr = 1'b1;
      end else if (br == 3) begin
        e.isErr = 1'b1;
        e.tail  = GAP + 1;
      end
    end
    return e;
  endfunction

  task automatic queueExpect(input logic [15:0] cmd, input int extra, input int br, input bit abort);
    planT p;
    p.extra = extra;
    p.br    = br;
    expQ.push_back(predict(cmd, extra, br, abort));
    planQ.push_back(p);
  endtask

  task automatic applyStimulus(input logic [15:0] cmd, input int extra, input int br, input bit abort);
    int t;
    t = 0;
    while (!bus.cmd_ready && t < 4000) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 4000) reportFail("cmdReadyWait", $sformatf("waited %0d cycles, required cmd_ready within 4000", t));
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = cmd;
    queueExpect(cmd, extra, br, abort);
    @(negedge CLK);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int t;
    t = 0;
    @(negedge CLK);
    while (!(expQ.size() == 0 && bus.idle) && t < 5000) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 5000) reportFail(name, $sformatf("waited %0d cycles with %0d pending, required drain within 5000", t, expQ.size()));
  endtask

  task automatic waitBusControl(input logic [1:0] value, input string name);
    int t;
    t = 0;
    while (bus.BusControl != value && t < 2000) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 2000) reportFail(name, $sformatf("BusControl stayed %0d, required %0d within 2000 cycles", bus.BusControl, value));
  endtask

  // Sound-chip responder: stretches byte1 with BUSY and injects one BR cycle as each command's plan asks.
  planT       cur;
  logic [1:0] rPrev;
  int         k;
  bit         inTail;
  initial begin
    bus.BUSY  = 1'b0;
    bus.BR    = 1'b0;
    rPrev     = 2'b00;
    k         = 0;
    inTail    = 1'b0;
    cur.extra = 0;
    cur.br    = 0;
    forever begin
      @(negedge CLK);
      bus.BUSY = 1'b0;
      bus.BR   = 1'b0;
      if (!RST) begin
        rPrev  = 2'b00;
        inTail = 1'b0;
      end else begin
        if (bus.BusControl == 2'b01) begin
          if (rPrev != 2'b01) begin
            if (planQ.size() > 0) cur = planQ.pop_front();
            else begin
              cur.extra = 0;
              cur.br    = 0;
            end
            k      = 0;
            inTail = 1'b0;
          end
          k++;
          bus.BUSY = (k < HOLD + cur.extra);
          bus.BR   = (cur.br == 1 && k == 1);
        end else if (bus.BusControl == 2'b10) begin
          if (rPrev != 2'b10) k = 0;
          k++;
          bus.BR = (cur.br == 2 && k == 1);
        end else begin
          if (rPrev == 2'b01 || rPrev == 2'b10) begin
            k      = 0;
            inTail = 1'b1;
          end
          if (inTail) begin
            k++;
            bus.BR = (cur.br == 3 && k == 1);
          end
        end
        rPrev = bus.BusControl;
      end
    end
  end

  // Monitor: measures each command's phases on the bus and scores it when a pulse appears.
  logic [1:0] prevBC;
  bit         active;
  bit         glitch;
  logic [7:0] rb1;
  logic [7:0] rb2;
  int         rb1Len;
  int         rb2Len;
  int         rTail;
  int         expErr;

  task automatic scoreEvent();
    expT e;
    while (expQ.size() > 0 && expQ[0].abort) e = expQ.pop_front();
    if (expQ.size() == 0) begin
      reportFail("spuriousPulse", $sformatf("got done=%0d err=%0d, expected no pulse", bus.done_pulse, bus.err_pulse));
    end else begin
      e = expQ.pop_front();
      checkOutput("singlePulse", int'(bus.done_pulse && bus.err_pulse), 0);
      checkOutput("pulseIsErr", bus.err_pulse, e.isErr);
      checkOutput("byte1", rb1, e.b1);
      checkOutput("byte1Len", rb1Len, e.b1Len);
      checkOutput("byte2Len", rb2Len, e.b2Len);
      if (e.b2Len > 0) checkOutput("byte2", rb2, e.b2);
      checkOutput("idleTail", rTail, e.tail);
      checkOutput("busStable", glitch, 0);
      if (e.isErr && expErr < 255) expErr++;
      checkOutput("errCount", bus.err_count, expErr);
    end
    if (bus.done_pulse) doneSeen++;
    if (bus.err_pulse) errSeen++;
    active = 1'b0;
  endtask

  initial begin
    prevBC = 2'b00;
    active = 1'b0;
    glitch = 1'b0;
    rb1 = 8'd0;
    rb2 = 8'd0;
    rb1Len = 0;
    rb2Len = 0;
    rTail = 0;
    expErr = 0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        active = 1'b0;
        prevBC = 2'b00;
        expErr = 0;
      end else begin
        case (bus.BusControl)
          2'b01: begin
            if (prevBC != 2'b01) begin
              active = 1'b1;
              glitch = 1'b0;
              rb1    = bus.Data;
              rb2    = 8'd0;
              rb1Len = 0;
              rb2Len = 0;
              rTail  = 0;
            end
            rb1Len++;
            if (bus.Data != rb1) glitch = 1'b1;
          end
          2'b10: begin
            if (prevBC != 2'b10) rb2 = bus.Data;
            rb2Len++;
            if (bus.Data != rb2) glitch = 1'b1;
          end
          2'b00: begin
            if (active) begin
              rTail++;
              if (bus.Data != 8'd0) glitch = 1'b1;
            end
          end
          default: reportFail("busControl11", "got BusControl=3, required never driven");
        endcase
        if (bus.done_pulse || bus.err_pulse) scoreEvent();
        prevBC = bus.BusControl;
      end
    end
  end

  int         doneBefore;
  int         errBefore;
  logic [15:0] c;
  int         extra;
  int         r;

  initial begin
    RST           = 1'b1;
    bus.enable    = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 16'd0;
    #2 RST = 1'b0;
    #3;
    checkOutput("rstBusControl", bus.BusControl, 0);
    checkOutput("rstData", bus.Data, 0);
    checkOutput("rstDone", bus.done_pulse, 0);
    checkOutput("rstErr", bus.err_pulse, 0);
    checkOutput("rstErrCount", bus.err_count, 0);
    checkOutput("rstLevel", bus.fifo_level, 0);
    checkOutput("rstReady", bus.cmd_ready, 1);
    checkOutput("rstIdle", bus.idle, 1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    bus.enable = 1'b1;

    // Tone, status, BUSY-stretched wavetable, BR in byte2, then a follow-on command.
    applyStimulus(16'h5ABC, 0, 0, 1'b0);
    applyStimulus(16'h0D00, 0, 0, 1'b0);
    applyStimulus(16'hA512, 4, 0, 1'b0);
    applyStimulus(16'h6677, 0, 2, 1'b0);
    applyStimulus(16'h4321, 0, 0, 1'b0);
    waitIdle("drainDirected");
    checkOutput("errAfterBr", bus.err_count, 1);

    bus.enable = 1'b0;
    doneBefore = doneSeen;
    for (int i = 0; i < 5; i++) begin
      c = 16'h4100 + 16'(i * 16'h0111);
      checkOutput($sformatf("readyPush%0d", i), bus.cmd_ready, (i < 4) ? 1 : 0);
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = c;
      if (i < 4) queueExpect(c, 0, 0, 1'b0);
      @(negedge CLK);
    end
    bus.cmd_valid = 1'b0;
    checkOutput("fullLevel", bus.fifo_level, 4);
    checkOutput("fullReady", bus.cmd_ready, 0);
    checkOutput("fullIdle", bus.idle, 0);
    repeat (5) @(negedge CLK);
    checkOutput("noPopDisabled", bus.fifo_level, 4);
    bus.enable = 1'b1;
    waitIdle("drainFull");
    checkOutput("fourDone", doneSeen - doneBefore, 4);

    applyStimulus(16'h8899, 400, 0, 1'b0);
    waitIdle("drainStuck");
    checkOutput("errAfterStuck", bus.err_count, 2);

    for (int i = 0; i < 60; i++) begin
      c     = 16'($urandom);
      extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      r     = int'($urandom_range(0, 9));
      applyStimulus(c, extra, (r >= 7) ? r - 6 : 0, 1'b0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 12)) @(negedge CLK);
    end
    waitIdle("drainRandom");

    // Abort a command mid-byte2 by dropping enable; the queued one must still run.
    doneBefore = doneSeen;
    errBefore  = errSeen;
    applyStimulus(16'h7A11, 0, 0, 1'b1);
    applyStimulus(16'h1B22, 0, 0, 1'b0);
    waitBusControl(2'b10, "abortWaitB2");
    bus.enable = 1'b0;
    repeat (2) @(negedge CLK);
    checkOutput("abortBusIdle", bus.BusControl, 0);
    checkOutput("abortLevel", bus.fifo_level, 1);
    checkOutput("abortNoDone", doneSeen - doneBefore, 0);
    checkOutput("abortNoErr", errSeen - errBefore, 0);
    bus.enable = 1'b1;
    waitIdle("drainAbort");
    checkOutput("afterAbortDone", doneSeen - doneBefore, 1);

    for (int i = 0; i < 256; i++) applyStimulus({8'(i), 8'h5C}, 0, 1, 1'b0);
    waitIdle("drainSaturate");
    checkOutput("errSaturated", bus.err_count, 255);

    applyStimulus(16'h5A5A, 0, 0, 1'b0);
    applyStimulus(16'h1111, 0, 0, 1'b0);
    waitBusControl(2'b01, "resetWaitB1");
    RST = 1'b0;
    #1;
    checkOutput("midRstBusControl", bus.BusControl, 0);
    checkOutput("midRstData", bus.Data, 0);
    checkOutput("midRstLevel", bus.fifo_level, 0);
    checkOutput("midRstReady", bus.cmd_ready, 1);
    checkOutput("midRstIdle", bus.idle, 1);
    checkOutput("midRstErrCount", bus.err_count, 0);
    expQ.delete();
    planQ.delete();
    repeat (2) @(negedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    applyStimulus(16'hC3A5, 1, 0, 1'b0);
    waitIdle("drainRecover");

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
